dpsk_modulator_edr: RTL and testbench
=====================================

DPSK_MODULATOR_EDR -- requirements
Module: dpsk_modulator_edr

Interface
REQ-001 SHALL have parameter RE_IM_SIZE, default 12, signed width of each I/Q output sample (min 12).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, symbol buffer depth (power of two, min 4).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  one serial bit present on data_in this cycle.
REQ-006 SHALL have port data_in  input  1  serial payload bit.
REQ-007 SHALL have port mode  input  2  00 DBPSK, 01 pi/4-DQPSK, 10 8DPSK, 11 treated as 01.
REQ-008 SHALL have port enable  input  1  permits symbol output from the buffer.
REQ-009 SHALL have port valid_out  output  1  data_out_re/im hold a valid sample.
REQ-010 SHALL have ports data_out_re and data_out_im  output  RE_IM_SIZE  two's-complement I and Q.
REQ-011 SHALL have port finished  output  1  high when idle, low during a burst.
REQ-012 SHALL have ports full and overflow  output  1 each  buffer full; sticky lost-symbol flag.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on first valid_in; RUN->DRAIN on first cycle valid_in low; DRAIN->IDLE the cycle after the last buffered symbol is output.
REQ-014 SHALL latch mode on the IDLE->RUN transition; mode changes during RUN/DRAIN SHALL be ignored.
REQ-015 SHALL pack bits into symbols of 1/2/3 bits (DBPSK/DQPSK/8DPSK), first received bit as symbol MSB, and write each completed symbol into the FIFO.
REQ-016 SHALL zero-pad a partial symbol at RUN->DRAIN and write it as a final symbol.
REQ-017 SHALL, when enable=1 and FIFO non-empty, pop one symbol per cycle; valid_out SHALL assert exactly one cycle after the pop (latency 1), samples registered.
REQ-018 SHALL keep a 3-bit phase index p (units of 45 deg), cleared to 0 at IDLE->RUN, updated p = p + inc mod 8 per popped symbol.
REQ-019 SHALL use inc: DBPSK 0->0, 1->4; DQPSK 00->1, 01->3, 11->5, 10->7; 8DPSK 000->0, 001->1, 011->2, 010->3, 110->4, 111->5, 101->6, 100->7.
REQ-020 SHALL map new p to constant LUT (I,Q), p=0..7: (512,0),(362,362),(0,512),(-362,362),(-512,0),(-362,-362),(0,-512),(362,-362), sign-extended to RE_IM_SIZE.
REQ-021 SHALL assert full when FIFO holds FIFO_DEPTH symbols; a write while full with no same-cycle pop SHALL drop the symbol and set overflow; write and pop in the same cycle when full SHALL both succeed.
REQ-022 SHALL hold overflow until reset or next IDLE->RUN.
REQ-023 SHALL drive finished=0 from the cycle after IDLE->RUN until DRAIN->IDLE, then 1.
REQ-024 SHALL, with enable=0 in DRAIN, hold the FIFO and stay in DRAIN; valid_out=0 with data_out_re/im holding their last values.
REQ-025 SHALL ignore valid_in during DRAIN (bits discarded).

Reset
REQ-026 SHALL on reset=1 at a clk edge: state IDLE, FIFO empty, p=0, bit packer cleared, valid_out=0, data_out_re=0, data_out_im=0, finished=1, full=0, overflow=0.
REQ-027 SHALL let reset abort a burst in any state, discarding buffered symbols.

Configuration
REQ-028 SHALL, with macro DPSK_MODULATOR_8DPSK_EN defined, support mode 10 as 8DPSK per REQ-015/019.
REQ-029 SHALL, without DPSK_MODULATOR_8DPSK_EN, omit 3-bit packing and 8DPSK increments and treat mode 10 as 01.

Verification
REQ-030 SHALL cover DQPSK, enable=1, bits 0,0,0,1 -> samples (362,362) then (-512,0), finished back to 1.
REQ-031 SHALL cover DBPSK, bits 1,0,1 -> (-512,0),(-512,0),(512,0).
REQ-032 SHALL cover DQPSK odd burst 0,1,1 -> padded symbols 01,10 -> (-362,362),(0,512).
REQ-033 SHALL cover 8DPSK (macro on) bits 1,1,0,0,0,1 -> (-512,0),(-362,-362); macro off same mode -> DQPSK mapping.
REQ-034 SHALL cover FIFO_DEPTH=4, enable=0, DQPSK 10 bits -> full=1, overflow=1, then enable=1 -> exactly 4 samples.
REQ-035 SHALL cover reset=1 asserted mid-DRAIN -> next cycle valid_out=0, outputs 0, finished=1, FIFO empty.

Source files
------------

// File: rtl/dpsk_modulator_edr.sv
// dpsk_modulator_edr: differential PSK modulator for EDR payloads.
// Serial bits are packed into DBPSK / pi/4-DQPSK / 8DPSK symbols, buffered
// in a small FIFO, and turned into I/Q samples by accumulating a 3-bit
// phase index (45 degree steps) and looking it up in a constant table.
// Build option: define DPSK_MODULATOR_8DPSK_EN to enable 8DPSK (mode 10);
// without it mode 10 behaves like pi/4-DQPSK.
module dpsk_modulator_edr #(
  parameter int RE_IM_SIZE = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic                         data_in,
  input  logic [1:0]                   mode,
  input  logic                         enable,
  output logic                         valid_out,
  output logic signed [RE_IM_SIZE-1:0] data_out_re,
  output logic signed [RE_IM_SIZE-1:0] data_out_im,
  output logic                         finished,
  output logic                         full,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Bits per symbol for a mode code; 11 (and 10 without 8DPSK) fold onto DQPSK.
  function automatic logic [1:0] sym_len_of(input logic [1:0] m);
    logic [1:0] len;
    case (m)
      2'b00:   len = 2'd1;
`ifdef DPSK_MODULATOR_8DPSK_EN
      2'b10:   len = 2'd3;
`endif
      default: len = 2'd2;
    endcase
    return len;
  endfunction

  // Phase increment (45 degree units) for a symbol of the given length.
  function automatic logic [2:0] inc_of(input logic [1:0] len, input logic [2:0] sym);
    logic [2:0] inc;
    inc = 3'd0;
    if (len == 2'd1) begin
      inc = {sym[0], 2'b00};
`ifdef DPSK_MODULATOR_8DPSK_EN
    end else if (len == 2'd3) begin
      case (sym)
        3'b000:  inc = 3'd0;
        3'b001:  inc = 3'd1;
        3'b011:  inc = 3'd2;
        3'b010:  inc = 3'd3;
        3'b110:  inc = 3'd4;
        3'b111:  inc = 3'd5;
        3'b101:  inc = 3'd6;
        default: inc = 3'd7;
      endcase
`endif
    end else begin
      case (sym[1:0])
        2'b00:   inc = 3'd1;
        2'b01:   inc = 3'd3;
        2'b11:   inc = 3'd5;
        default: inc = 3'd7;
      endcase
    end
    return inc;
  endfunction

  // Constellation table, amplitude 512 (362 ~= 512/sqrt(2)).
  function automatic logic signed [11:0] lut_re(input logic [2:0] p);
    logic signed [11:0] v;
    case (p)
      3'd0:    v = 12'sd512;
      3'd1:    v = 12'sd362;
      3'd2:    v = 12'sd0;
      3'd3:    v = -12'sd362;
      3'd4:    v = -12'sd512;
      3'd5:    v = -12'sd362;
      3'd6:    v = 12'sd0;
      default: v = 12'sd362;
    endcase
    return v;
  endfunction

  function automatic logic signed [11:0] lut_im(input logic [2:0] p);
    logic signed [11:0] v;
    case (p)
      3'd0:    v = 12'sd0;
      3'd1:    v = 12'sd362;
      3'd2:    v = 12'sd512;
      3'd3:    v = 12'sd362;
      3'd4:    v = 12'sd0;
      3'd5:    v = -12'sd362;
      3'd6:    v = -12'sd512;
      default: v = -12'sd362;
    endcase
    return v;
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              sym_len_q, sym_len_d;
  logic [2:0]              bits_q, bits_d;
  logic [1:0]              bit_cnt_q, bit_cnt_d;
  logic [2:0]              phase_q, phase_d;
  logic                    overflow_q, overflow_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    valid_q, valid_d;
  logic signed [RE_IM_SIZE-1:0] re_q, re_d, im_q, im_d;
  logic [2:0]              fifo_mem [FIFO_DEPTH];

  logic       start;
  logic       wr_en, wr_ok, pop, fifo_full;
  logic [2:0] wr_data, rd_data, packed_bits, pad_sym;
  logic [1:0] cur_len, cnt_inc;
  logic [2:0] phase_new;

  assign start       = (state_q == S_IDLE) && valid_in;
  assign cur_len     = (state_q == S_IDLE) ? sym_len_of(mode) : sym_len_q;
  assign packed_bits = {bits_q[1:0], data_in};
  assign cnt_inc     = bit_cnt_q + 2'd1;
  assign fifo_full   = (count_q == DEPTH_C);
  assign pop         = enable && (count_q != '0);
  assign wr_ok       = wr_en && (!fifo_full || pop);
  assign rd_data     = fifo_mem[rd_ptr_q];
  assign phase_new   = phase_q + inc_of(sym_len_q, rd_data);

  // Burst state machine and MSB-first bit packer feeding the symbol FIFO.
  always_comb begin
    state_d   = state_q;
    sym_len_d = sym_len_q;
    bits_d    = bits_q;
    bit_cnt_d = bit_cnt_q;
    wr_en     = 1'b0;
    wr_data   = 3'b000;
    pad_sym   = 3'b000;
    case (bit_cnt_q)
      2'd1:    pad_sym = (sym_len_q == 2'd2) ? {1'b0, bits_q[0], 1'b0} : {bits_q[0], 2'b00};
      2'd2:    pad_sym = {bits_q[1:0], 1'b0};
      default: pad_sym = 3'b000;
    endcase
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d   = S_RUN;
          sym_len_d = sym_len_of(mode);
        end
      end
      S_RUN: begin
        if (!valid_in) begin
          state_d   = S_DRAIN;
          bits_d    = 3'b000;
          bit_cnt_d = 2'd0;
          if (bit_cnt_q != 2'd0) begin
            wr_en   = 1'b1;
            wr_data = pad_sym;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Bits are only taken in IDLE (first bit of a burst) and RUN.
    if (valid_in && (state_q != S_DRAIN)) begin
      if (cnt_inc == cur_len) begin
        wr_en     = 1'b1;
        wr_data   = packed_bits;
        bits_d    = 3'b000;
        bit_cnt_d = 2'd0;
      end else begin
        bits_d    = packed_bits;
        bit_cnt_d = cnt_inc;
      end
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (start) overflow_d = 1'b0;
    else if (wr_en && fifo_full && !pop) overflow_d = 1'b1;
  end

  // Phase accumulation and registered I/Q output, one cycle after a pop.
  always_comb begin
    phase_d = phase_q;
    valid_d = 1'b0;
    re_d    = re_q;
    im_d    = im_q;
    if (start) begin
      phase_d = 3'd0;
    end else if (pop) begin
      phase_d = phase_new;
      valid_d = 1'b1;
      re_d    = RE_IM_SIZE'(lut_re(phase_new));
      im_d    = RE_IM_SIZE'(lut_im(phase_new));
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sym_len_q  <= 2'd2;
      bits_q     <= 3'b000;
      bit_cnt_q  <= 2'd0;
      phase_q    <= 3'd0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
    end else begin
      state_q    <= state_d;
      sym_len_q  <= sym_len_d;
      bits_q     <= bits_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      re_q       <= re_d;
      im_q       <= im_d;
    end
  end

  // Symbol storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_ok) fifo_mem[wr_ptr_q] <= wr_data;
  end

  assign valid_out   = valid_q;
  assign data_out_re = re_q;
  assign data_out_im = im_q;
  assign finished    = (state_q == S_IDLE);
  assign full        = fifo_full;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_dpsk_modulator_edr.sv
// Bench for dpsk_modulator_edr: directed scenarios plus randomized bursts
// compared with an arithmetic model of the modulation rules.
module tb_dpsk_modulator_edr;

  localparam int W = 12;
  localparam int D = 4;
`ifdef DPSK_MODULATOR_8DPSK_EN
  localparam bit EN8 = 1'b1;
`else
  localparam bit EN8 = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, valid_in = 1'b0, data_in = 1'b0, enable = 1'b1;
  logic [1:0] mode = 2'b01;
  logic valid_out, finished, full, overflow;
  logic signed [W-1:0] data_out_re, data_out_im;

  dpsk_modulator_edr #(.RE_IM_SIZE(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .mode(mode), .enable(enable), .valid_out(valid_out),
    .data_out_re(data_out_re), .data_out_im(data_out_im),
    .finished(finished), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tick_no, first_tick;
  int cap_re[$], cap_im[$], exp_re[$], exp_im[$];
  bit burst_bits[$];

  // Unit circle at 45 degree steps, amplitude 512.
  int cos_tab[8] = '{512, 362, 0, -362, -512, -362, 0, 362};
  int sin_tab[8] = '{0, 362, 512, 362, 0, -362, -512, -362};
  // Gray-coded symbol value -> phase step
  int dq_step[4] = '{1, 3, 7, 5};
  int ed_step[8] = '{0, 1, 3, 2, 7, 6, 4, 5};

  function automatic int bits_per_sym(input logic [1:0] m);
    if (m == 2'b00) return 1;
    if (m == 2'b10 && EN8) return 3;
    return 2;
  endfunction

  // Reference: chunk bits, zero-pad the tail, accumulate phase, look up I/Q.
  task automatic model(input logic [1:0] m);
    int n, p, sym, step;
    n = bits_per_sym(m);
    p = 0;
    exp_re.delete();
    exp_im.delete();
    for (int i = 0; i < burst_bits.size(); i += n) begin
      sym = 0;
      for (int k = 0; k < n; k++)
        sym = sym * 2 + ((i + k < burst_bits.size()) ? int'(burst_bits[i + k]) : 0);
      if (n == 1) step = sym * 4;
      else if (n == 2) step = dq_step[sym];
      else step = ed_step[sym];
      p = (p + step) % 8;
      exp_re.push_back(cos_tab[p]);
      exp_im.push_back(sin_tab[p]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (valid_out === 1'b1) begin
      cap_re.push_back(int'(data_out_re));
      cap_im.push_back(int'(data_out_im));
      if (first_tick < 0) first_tick = tick_no;
    end
  endtask

  task automatic clear_capture();
    cap_re.delete();
    cap_im.delete();
    tick_no = 0;
    first_tick = -1;
  endtask

  // Drive burst_bits serially, then wait (bounded) for finished.
  task automatic send_burst(input logic [1:0] m, input bit scramble_mode);
    int n;
    clear_capture();
    for (int i = 0; i < burst_bits.size(); i++) begin
      valid_in = 1'b1;
      data_in  = burst_bits[i];
      mode     = (i == 0 || !scramble_mode) ? m : 2'($urandom_range(0, 3));
      tick();
    end
    valid_in = 1'b0;
    data_in  = 1'b0;
    n = 0;
    while (finished !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (finished !== 1'b1) begin
      fails++;
      $display("FAIL burst_timeout: finished=%b required 1 after %0d cycles", finished, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if ({valid_out, finished, full, overflow} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_flags: v/fin/full/ovf=%b required 0100", {valid_out, finished, full, overflow});
    end
    tests++;
    if (data_out_re !== '0 || data_out_im !== '0) begin
      fails++;
      $display("FAIL reset_data: re=%0d im=%0d required 0 0", data_out_re, data_out_im);
    end
  endtask

  task automatic test_directed(input string name, input logic [1:0] m, input int first_exp);
    send_burst(m, 1'b0);
    $display("[TB] %s: %0d samples, first at cycle %0d", name, cap_re.size(), first_tick);
    tests++;
    if (cap_re.size() !== exp_re.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d required %0d", name, cap_re.size(), exp_re.size());
    end else begin
      for (int i = 0; i < exp_re.size(); i++) begin
        tests++;
        if (cap_re[i] !== exp_re[i] || cap_im[i] !== exp_im[i]) begin
          fails++;
          $display("FAIL %s_sample%0d: got (%0d,%0d) required (%0d,%0d)", name, i, cap_re[i], cap_im[i], exp_re[i], exp_im[i]);
        end
      end
    end
    tests++;
    if (first_tick !== first_exp) begin
      fails++;
      $display("FAIL %s_latency: first valid at %0d required %0d", name, first_tick, first_exp);
    end
  endtask

  task automatic test_dqpsk();
    burst_bits = '{0, 0, 0, 1};
    exp_re = '{362, -512};
    exp_im = '{362, 0};
    test_directed("dqpsk", 2'b01, 3);
  endtask

  task automatic test_dbpsk();
    burst_bits = '{1, 0, 1};
    exp_re = '{-512, -512, 512};
    exp_im = '{0, 0, 0};
    test_directed("dbpsk", 2'b00, 2);
  endtask

  task automatic test_odd_burst();
    burst_bits = '{0, 1, 1};
    exp_re = '{-362, 0};
    exp_im = '{362, 512};
    test_directed("odd_pad", 2'b01, 3);
  endtask

  task automatic test_8dpsk();
    burst_bits = '{1, 1, 0, 0, 0, 1};
    if (EN8) begin
      exp_re = '{-512, -362};
      exp_im = '{0, -362};
      test_directed("8dpsk", 2'b10, 4);
    end else begin
      exp_re = '{-362, 0, 362};
      exp_im = '{-362, -512, 362};
      test_directed("8dpsk_off", 2'b10, 3);
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    int nb, fexp;
    for (int it = 0; it < 20; it++) begin
      m  = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 12);
      burst_bits.delete();
      for (int i = 0; i < nb; i++) burst_bits.push_back(1'($urandom_range(0, 1)));
      model(m);
      fexp = (nb >= bits_per_sym(m)) ? bits_per_sym(m) + 1 : nb + 2;
      send_burst(m, 1'b1);
      $display("[TB] random %0d: mode=%0d bits=%0d samples=%0d", it, m, nb, cap_re.size());
      tests++;
      if (cap_re.size() !== exp_re.size()) begin
        fails++;
        $display("FAIL rand%0d_count: got %0d required %0d", it, cap_re.size(), exp_re.size());
      end else begin
        for (int i = 0; i < exp_re.size(); i++) begin
          tests++;
          if (cap_re[i] !== exp_re[i] || cap_im[i] !== exp_im[i]) begin
            fails++;
            $display("FAIL rand%0d_sample%0d: got (%0d,%0d) required (%0d,%0d)", it, i, cap_re[i], cap_im[i], exp_re[i], exp_im[i]);
          end
        end
      end
      tests++;
      if (first_tick !== fexp) begin
        fails++;
        $display("FAIL rand%0d_latency: first valid at %0d required %0d", it, first_tick, fexp);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
    end
  endtask

  task automatic test_overflow();
    int old_re, old_im, n;
    old_re = int'(data_out_re);
    old_im = int'(data_out_im);
    burst_bits.delete();
    for (int i = 0; i < 10; i++) burst_bits.push_back(1'($urandom_range(0, 1)));
    model(2'b01);
    clear_capture();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1;
      data_in  = burst_bits[i];
      mode     = 2'b01;
      tick();
    end
    valid_in = 1'b0;
    tick();
    tests++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flags: full=%b overflow=%b required 1 1", full, overflow);
    end
    // Bits offered during DRAIN must be discarded.
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = 1'($urandom_range(0, 1));
      tick();
    end
    valid_in = 1'b0;
    tick();
    tests++;
    if (cap_re.size() !== 0 || finished !== 1'b0) begin
      fails++;
      $display("FAIL ovf_hold: samples=%0d finished=%b required 0 0", cap_re.size(), finished);
    end
    tests++;
    if (int'(data_out_re) !== old_re || int'(data_out_im) !== old_im) begin
      fails++;
      $display("FAIL ovf_data_hold: got (%0d,%0d) required (%0d,%0d)", data_out_re, data_out_im, old_re, old_im);
    end
    enable = 1'b1;
    n = 0;
    while (finished !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    $display("[TB] overflow: %0d samples after enable", cap_re.size());
    tests++;
    if (cap_re.size() !== 4) begin
      fails++;
      $display("FAIL ovf_count: got %0d required 4", cap_re.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (cap_re[i] !== exp_re[i] || cap_im[i] !== exp_im[i]) begin
          fails++;
          $display("FAIL ovf_sample%0d: got (%0d,%0d) required (%0d,%0d)", i, cap_re[i], cap_im[i], exp_re[i], exp_im[i]);
        end
      end
    end
    tests++;
    if (overflow !== 1'b1 || finished !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: overflow=%b finished=%b required 1 1", overflow, finished);
    end
  endtask

  task automatic test_full_pop_write();
    int n;
    burst_bits.delete();
    for (int i = 0; i < 12; i++) burst_bits.push_back(1'($urandom_range(0, 1)));
    model(2'b01);
    clear_capture();
    for (int i = 0; i < 12; i++) begin
      enable   = (i >= 9);
      valid_in = 1'b1;
      data_in  = burst_bits[i];
      mode     = 2'b01;
      if (i == 9) begin
        tests++;
        if (full !== 1'b1) begin
          fails++;
          $display("FAIL fpw_full: full=%b required 1", full);
        end
      end
      tick();
    end
    valid_in = 1'b0;
    n = 0;
    while (finished !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    $display("[TB] full_pop_write: %0d samples", cap_re.size());
    tests++;
    if (cap_re.size() !== exp_re.size() || overflow !== 1'b0) begin
      fails++;
      $display("FAIL fpw_count: got %0d ovf=%b required %0d ovf=0", cap_re.size(), overflow, exp_re.size());
    end else begin
      for (int i = 0; i < exp_re.size(); i++) begin
        tests++;
        if (cap_re[i] !== exp_re[i] || cap_im[i] !== exp_im[i]) begin
          fails++;
          $display("FAIL fpw_sample%0d: got (%0d,%0d) required (%0d,%0d)", i, cap_re[i], cap_im[i], exp_re[i], exp_im[i]);
        end
      end
    end
  endtask

  task automatic test_reset_drain();
    clear_capture();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = 1'b1;
      mode     = 2'b00;
      tick();
    end
    valid_in = 1'b0;
    tick();
    tick();
    tests++;
    if (finished !== 1'b0) begin
      fails++;
      $display("FAIL rstd_pre: finished=%b required 0", finished);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (valid_out !== 1'b0 || data_out_re !== '0 || data_out_im !== '0 || finished !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL rstd_state: v=%b re=%0d im=%0d fin=%b full=%b required 0 0 0 1 0", valid_out, data_out_re, data_out_im, finished, full);
    end
    enable = 1'b1;
    clear_capture();
    for (int i = 0; i < 5; i++) tick();
    $display("[TB] reset_drain: %0d samples after reset", cap_re.size());
    tests++;
    if (cap_re.size() !== 0 || finished !== 1'b1) begin
      fails++;
      $display("FAIL rstd_empty: samples=%0d finished=%b required 0 1", cap_re.size(), finished);
    end
  endtask

  initial begin
    test_reset();
    test_dqpsk();
    test_dbpsk();
    test_odd_burst();
    test_8dpsk();
    test_random();
    test_overflow();
    test_full_pop_write();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
